ldpc_dec_ctrl: RTL and testbench
================================

# ldpc_dec_ctrl

Sequencing controller for the quasi-cyclic LDPC decoder array (C×R cyclic-shift blocks, C·D check-node units, R·D variable-node units). Loads the per-block shift configuration and the R·D channel LLRs into the datapath. It then runs a bounded number of message-passing iterations and captures the hard-decision vector. Finally it hands the decoded word to the downstream consumer over a valid/ready handshake.

## Interface
Parameters:
- `data_w`, 8, LLR/message width
- `R`, 5, block columns (variable-node groups)
- `C`, 3, block rows (check-node groups)
- `D`, 8, circulant size
- `MAX_ITER`, 10, iteration limit (1..255)
- `ITER_CYC`, 4, clock cycles per decoding iteration (≥1, datapath pipeline depth)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a codeword; honoured only in IDLE
- `cfg_we`  in  1  shift-value write strobe
- `cfg_addr`  in  clog2(C*R)  block index i*R+j
- `cfg_data`  in  data_w  shift value
- `mtx_we`, `mtx_addr`, `mtx_data`  out  1 / clog2(C*R) / data_w  forwarded shift write to datapath
- `llr_valid`  in  1  LLR input valid
- `llr_data`  in  data_w  LLR, variable-node order 0..R*D-1
- `llr_ready`  out  1  LLR accepted when valid&ready
- `l_we`, `l_addr`, `l_data`  out  1 / clog2(R*D) / data_w  LLR write to datapath
- `dp_clr`  out  1  one-cycle clear of datapath message state
- `dp_run`  out  1  datapath iterating
- `dec`  in  R*D  hard decisions from VNUs
- `syn_zero`  in  1  syndrome checker: all parity checks satisfied
- `out_valid`  out  1  decoded word available
- `out_ready`  in  1  consumer accepts
- `dec_out`  out  R*D  captured decoded word
- `iter_out`  out  8  iterations executed for `dec_out`
- `converged`  out  1  `syn_zero` was 1 at capture
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, CLEAR, RUN, DONE.
- IDLE: `cfg_we` with `cfg_addr` < C*R forwards to `mtx_*` on the next cycle (registered). Writes with address ≥ C*R, and all writes in other states, are dropped. `start` → LOAD, with the LLR counter cleared. A `start` coincident with `cfg_we` performs both.
- LOAD: `llr_ready`=1. Each valid&ready beat produces a registered `l_we`=1, `l_addr`=count, `l_data`=data, then the counter increments. The beat at count R*D-1 → CLEAR. `start` is ignored.
- CLEAR: `dp_clr`=1 for exactly one cycle; iteration counter and cycle counter zeroed → RUN.
- RUN: `dp_run`=1. The cycle counter runs 0..ITER_CYC-1. At ITER_CYC-1 the iteration counter increments, and the block evaluates terminate = (iter+1 == MAX_ITER) or early-exit (see Configuration).
- On terminate: `dec_out`←`dec`, `iter_out`←iter+1, `converged`←`syn_zero`, then → DONE. Otherwise the cycle counter wraps to 0.
- DONE: `out_valid`=1. `dec_out`, `iter_out` and `converged` are held stable until out_valid&out_ready, then → IDLE. `start` seen in DONE is ignored, not queued.
- `rst` asserted in any state: immediate return to IDLE, and a partial load is discarded.

## Timing
- All outputs reset to 0 (state IDLE, counters 0, `dec_out` 0).
- `mtx_*` and `l_*` are registered: 1-cycle latency from the accepted input.
- `start` to first possible `llr_ready`: 1 cycle.
- Cycle budget with no stalls, last LLR beat to `out_valid`: 1 (CLEAR) + N·ITER_CYC cycles, where N = iterations executed.
- `syn_zero` and `dec` are sampled only on the last cycle of each iteration.
- `out_valid` rises the cycle after capture. The DONE→IDLE transition happens on the handshake edge, and `busy` falls on the same edge.

## Configuration
- `LDPC_EARLY_TERM_EN` defined: terminate also when `syn_zero`=1 at the end of any iteration, so `iter_out` can be less than MAX_ITER.
- Undefined: always exactly MAX_ITER iterations. `syn_zero` only sets `converged`.

## Test plan
- Config: in IDLE, write `cfg_addr`=7 with `cfg_data`=5, then `cfg_addr`=15. Required: one `mtx_we` pulse with addr 7 and data 5; the write to 15 is dropped. A write during RUN is dropped.
- Load: `start`, then 40 LLRs of value k with `llr_valid` toggling every other cycle. Required: 40 `l_we` pulses with addr=data=0..39 in order, then one `dp_clr` pulse.
- Full run, macro off, `syn_zero`=1 throughout. Required: `out_valid` exactly 1+40 cycles after the last LLR, with `iter_out`=10 and `converged`=1.
- Early exit, macro on: `syn_zero` rises during iteration 3. Required: capture at the end of iteration 3, `iter_out`=3, `converged`=1, `dec_out` equal to `dec` at that cycle.
- Backpressure: `out_ready`=0 for 20 cycles. Required: `out_valid` and `dec_out` stable and `start` ignored; IDLE reached on the first `out_ready`=1.
- Reset mid-LOAD after 17 beats. Required: all outputs 0 and `busy`=0 immediately. A new `start` reloads from `l_addr`=0.

Source files
------------

// File: rtl/ldpc_dec_ctrl.sv
// Sequencing controller for the QC-LDPC decoder array: config/LLR load, bounded iteration, result handoff.
// Optional feature macro: LDPC_EARLY_TERM_EN (stop as soon as the syndrome is zero at an iteration boundary).
module ldpc_dec_ctrl #(
  parameter int unsigned data_w   = 8,
  parameter int unsigned R        = 5,
  parameter int unsigned C        = 3,
  parameter int unsigned D        = 8,
  parameter int unsigned MAX_ITER = 10,
  parameter int unsigned ITER_CYC = 4,
  localparam int unsigned NBLK    = C * R,
  localparam int unsigned NVAR    = R * D,
  localparam int unsigned CFG_AW  = (NBLK > 1) ? $clog2(NBLK) : 1,
  localparam int unsigned L_AW    = (NVAR > 1) ? $clog2(NVAR) : 1,
  localparam int unsigned CYC_W   = (ITER_CYC > 1) ? $clog2(ITER_CYC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [data_w-1:0] cfg_data,
  output logic              mtx_we,
  output logic [CFG_AW-1:0] mtx_addr,
  output logic [data_w-1:0] mtx_data,
  input  logic              llr_valid,
  input  logic [data_w-1:0] llr_data,
  output logic              llr_ready,
  output logic              l_we,
  output logic [L_AW-1:0]   l_addr,
  output logic [data_w-1:0] l_data,
  output logic              dp_clr,
  output logic              dp_run,
  input  logic [NVAR-1:0]   dec,
  input  logic              syn_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NVAR-1:0]   dec_out,
  output logic [7:0]        iter_out,
  output logic              converged,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [L_AW-1:0]     llr_cnt_q, llr_cnt_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [7:0]          iter_q, iter_d;
  logic                mtx_we_q, mtx_we_d;
  logic [CFG_AW-1:0]   mtx_addr_q, mtx_addr_d;
  logic [data_w-1:0]   mtx_data_q, mtx_data_d;
  logic                llr_ready_q, llr_ready_d;
  logic                l_we_q, l_we_d;
  logic [L_AW-1:0]     l_addr_q, l_addr_d;
  logic [data_w-1:0]   l_data_q, l_data_d;
  logic                dp_clr_q, dp_clr_d;
  logic                dp_run_q, dp_run_d;
  logic                out_valid_q, out_valid_d;
  logic [NVAR-1:0]     dec_out_q, dec_out_d;
  logic [7:0]          iter_out_q, iter_out_d;
  logic                converged_q, converged_d;
  logic                busy_q, busy_d;

  logic                cfg_ok_c;
  logic                llr_last_c;
  logic                cyc_last_c;
  logic                iter_last_c;
  logic                term_c;

  assign cfg_ok_c    = cfg_we && (32'(cfg_addr) < NBLK);
  assign llr_last_c  = (llr_cnt_q == L_AW'(NVAR - 1));
  assign cyc_last_c  = (cyc_q == CYC_W'(ITER_CYC - 1));
  assign iter_last_c = (8'(iter_q + 8'd1) == 8'(MAX_ITER));

`ifdef LDPC_EARLY_TERM_EN
  assign term_c = iter_last_c | syn_zero;
`else
  assign term_c = iter_last_c;
`endif

  // Next-state, counters and registered-output next values
  always_comb begin
    state_d     = state_q;
    llr_cnt_d   = llr_cnt_q;
    cyc_d       = cyc_q;
    iter_d      = iter_q;
    mtx_we_d    = 1'b0;
    mtx_addr_d  = mtx_addr_q;
    mtx_data_d  = mtx_data_q;
    l_we_d      = 1'b0;
    l_addr_d    = l_addr_q;
    l_data_d    = l_data_q;
    dec_out_d   = dec_out_q;
    iter_out_d  = iter_out_q;
    converged_d = converged_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_ok_c) begin
          mtx_we_d   = 1'b1;
          mtx_addr_d = cfg_addr;
          mtx_data_d = cfg_data;
        end
        if (start) begin
          state_d   = S_LOAD;
          llr_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (llr_valid && llr_ready_q) begin
          l_we_d   = 1'b1;
          l_addr_d = llr_cnt_q;
          l_data_d = llr_data;
          if (llr_last_c) begin
            state_d   = S_CLEAR;
            llr_cnt_d = '0;
          end else begin
            llr_cnt_d = llr_cnt_q + L_AW'(1);
          end
        end
      end
      S_CLEAR: begin
        iter_d  = '0;
        cyc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cyc_last_c) begin
          cyc_d  = '0;
          iter_d = iter_q + 8'd1;
          if (term_c) begin
            dec_out_d   = dec;
            iter_out_d  = iter_q + 8'd1;
            converged_d = syn_zero;
            state_d     = S_DONE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // State-decoded outputs are registered alongside the state they describe
    llr_ready_d = (state_d == S_LOAD);
    dp_clr_d    = (state_d == S_CLEAR);
    dp_run_d    = (state_d == S_RUN);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      llr_cnt_q   <= '0;
      cyc_q       <= '0;
      iter_q      <= '0;
      mtx_we_q    <= 1'b0;
      mtx_addr_q  <= '0;
      mtx_data_q  <= '0;
      llr_ready_q <= 1'b0;
      l_we_q      <= 1'b0;
      l_addr_q    <= '0;
      l_data_q    <= '0;
      dp_clr_q    <= 1'b0;
      dp_run_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dec_out_q   <= '0;
      iter_out_q  <= '0;
      converged_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      llr_cnt_q   <= llr_cnt_d;
      cyc_q       <= cyc_d;
      iter_q      <= iter_d;
      mtx_we_q    <= mtx_we_d;
      mtx_addr_q  <= mtx_addr_d;
      mtx_data_q  <= mtx_data_d;
      llr_ready_q <= llr_ready_d;
      l_we_q      <= l_we_d;
      l_addr_q    <= l_addr_d;
      l_data_q    <= l_data_d;
      dp_clr_q    <= dp_clr_d;
      dp_run_q    <= dp_run_d;
      out_valid_q <= out_valid_d;
      dec_out_q   <= dec_out_d;
      iter_out_q  <= iter_out_d;
      converged_q <= converged_d;
      busy_q      <= busy_d;
    end
  end

  assign mtx_we    = mtx_we_q;
  assign mtx_addr  = mtx_addr_q;
  assign mtx_data  = mtx_data_q;
  assign llr_ready = llr_ready_q;
  assign l_we      = l_we_q;
  assign l_addr    = l_addr_q;
  assign l_data    = l_data_q;
  assign dp_clr    = dp_clr_q;
  assign dp_run    = dp_run_q;
  assign out_valid = out_valid_q;
  assign dec_out   = dec_out_q;
  assign iter_out  = iter_out_q;
  assign converged = converged_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// Directed self-checking bench for ldpc_dec_ctrl: config table plus load/run/backpressure/reset sequences.
module tb_ldpc_dec_ctrl;

  localparam int unsigned NVAR = 40;

`ifdef LDPC_EARLY_TERM_EN
  localparam int RUN1_N = 5,  RUN1_ITER = 1,  RUN1_CONV = 1;
  localparam int RUN2_N = 13, RUN2_ITER = 3,  RUN2_CONV = 1;
`else
  localparam int RUN1_N = 41, RUN1_ITER = 10, RUN1_CONV = 1;
  localparam int RUN2_N = 41, RUN2_ITER = 10, RUN2_CONV = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            cfg_we;
  logic [3:0]      cfg_addr;
  logic [7:0]      cfg_data;
  logic            mtx_we;
  logic [3:0]      mtx_addr;
  logic [7:0]      mtx_data;
  logic            llr_valid;
  logic [7:0]      llr_data;
  logic            llr_ready;
  logic            l_we;
  logic [5:0]      l_addr;
  logic [7:0]      l_data;
  logic            dp_clr;
  logic            dp_run;
  logic [NVAR-1:0] dec;
  logic            syn_zero;
  logic            out_valid;
  logic            out_ready;
  logic [NVAR-1:0] dec_out;
  logic [7:0]      iter_out;
  logic            converged;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  ldpc_dec_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .mtx_we(mtx_we), .mtx_addr(mtx_addr), .mtx_data(mtx_data),
    .llr_valid(llr_valid), .llr_data(llr_data), .llr_ready(llr_ready),
    .l_we(l_we), .l_addr(l_addr), .l_data(l_data),
    .dp_clr(dp_clr), .dp_run(dp_run), .dec(dec), .syn_zero(syn_zero),
    .out_valid(out_valid), .out_ready(out_ready), .dec_out(dec_out),
    .iter_out(iter_out), .converged(converged), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic       exp_we;
    logic [3:0] exp_addr;
    logic [7:0] exp_data;
  } cfg_vec_t;

  cfg_vec_t cv[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_llr_ready", 64'(llr_ready), 64'(1));
    chk("start_busy", 64'(busy), 64'(1));
  endtask

  // Streams NVAR LLRs (value = index); optionally valid only every other cycle
  task automatic load(input bit toggle);
    int  k   = 0;
    int  cyc = 0;
    bit  tog = 1'b1;
    logic rdy;
    while (k < int'(NVAR) && cyc < 400) begin
      llr_valid = tog;
      llr_data  = 8'(k);
      rdy       = llr_ready;
      tick();
      cyc++;
      if (tog && rdy) begin
        chk("load_l_we", 64'(l_we), 64'(1));
        chk("load_l_addr", 64'(l_addr), 64'(k));
        chk("load_l_data", 64'(l_data), 64'(k));
        k++;
      end else begin
        chk("load_idle_l_we", 64'(l_we), 64'(0));
      end
      if (toggle) tog = ~tog;
    end
    llr_valid = 1'b0;
    chk("load_count", 64'(k), 64'(NVAR));
    chk("dp_clr_pulse", 64'(dp_clr), 64'(1));
    chk("load_ready_drop", 64'(llr_ready), 64'(0));
  endtask

  // Runs from the CLEAR cycle until out_valid, checking latency and captured results
  task automatic run_chk(input int exp_n, input int exp_iter, input int exp_conv,
                         input bit syn_window, input bit cfg_poke);
    int  n    = 0;
    bit  done = 1'b0;
    bit  bad  = 1'b0;
    logic [NVAR-1:0] dec_drv = '0;
    tick();
    chk("dp_clr_one_cycle", 64'(dp_clr), 64'(0));
    n = 1;
    while (!done && n < 200) begin
      dec_drv  = {8'($urandom), 32'($urandom)};
      dec      = dec_drv;
      syn_zero = syn_window ? ((n + 1 >= 11) && (n + 1 <= 13)) : 1'b1;
      cfg_we   = cfg_poke;
      cfg_addr = 4'd3;
      cfg_data = 8'h77;
      tick();
      n++;
      if (mtx_we || l_we || dp_clr) bad = 1'b1;
      if (out_valid) done = 1'b1;
      else if (!dp_run) bad = 1'b1;
    end
    cfg_we = 1'b0;
    chk("run_latency", 64'(n), 64'(exp_n));
    chk("run_iter_out", 64'(iter_out), 64'(exp_iter));
    chk("run_converged", 64'(converged), 64'(exp_conv));
    chk("run_dec_out", 64'(dec_out), 64'(dec_drv));
    chk("run_strobes", 64'(bad), 64'(0));
    chk("run_dp_run_off", 64'(dp_run), 64'(0));
  endtask

  initial begin
    logic [NVAR-1:0] held;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    llr_valid = 1'b0; llr_data = '0; dec = '0; syn_zero = 1'b0; out_ready = 1'b0;

    cv[0] = '{1'b1, 4'd7,  8'd5,   1'b1, 4'd7,  8'd5};
    cv[1] = '{1'b1, 4'd15, 8'd9,   1'b0, 4'd7,  8'd5};
    cv[2] = '{1'b0, 4'd3,  8'd1,   1'b0, 4'd7,  8'd5};
    cv[3] = '{1'b1, 4'd14, 8'hA5,  1'b1, 4'd14, 8'hA5};
    cv[4] = '{1'b1, 4'd0,  8'h3C,  1'b1, 4'd0,  8'h3C};

    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_llr_ready", 64'(llr_ready), 64'(0));
    chk("rst_dec_out", 64'(dec_out), 64'(0));
    chk("rst_iter_out", 64'(iter_out), 64'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      cfg_we = cv[i].we; cfg_addr = cv[i].addr; cfg_data = cv[i].data;
      tick();
      chk($sformatf("cfg%0d_we", i), 64'(mtx_we), 64'(cv[i].exp_we));
      chk($sformatf("cfg%0d_addr", i), 64'(mtx_addr), 64'(cv[i].exp_addr));
      chk($sformatf("cfg%0d_data", i), 64'(mtx_data), 64'(cv[i].exp_data));
    end
    cfg_we = 1'b0;
    tick();
    chk("cfg_pulse_single", 64'(mtx_we), 64'(0));

    // start together with a config write: both take effect
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 8'h11;
    do_start();
    cfg_we = 1'b0;
    chk("start_cfg_we", 64'(mtx_we), 64'(1));
    chk("start_cfg_addr", 64'(mtx_addr), 64'(2));

    load(1'b1);
    run_chk(RUN1_N, RUN1_ITER, RUN1_CONV, 1'b0, 1'b0);

    // Backpressure: result held, start ignored
    held = dec_out;
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'b0;
      start     = (i % 3 == 0);
      dec       = {8'($urandom), 32'($urandom)};
      tick();
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_dec_out", 64'(dec_out), 64'(held));
    end
    start = 1'b0; out_ready = 1'b1;
    tick();
    chk("hs_out_valid", 64'(out_valid), 64'(0));
    chk("hs_busy", 64'(busy), 64'(0));
    out_ready = 1'b0;
    tick();
    chk("start_not_queued", 64'(llr_ready), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));

    do_start();
    load(1'b0);
    run_chk(RUN2_N, RUN2_ITER, RUN2_CONV, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("run2_release", 64'(busy), 64'(0));

    // Reset in the middle of a load
    do_start();
    llr_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      llr_data = 8'(i);
      tick();
    end
    chk("mid_l_addr", 64'(l_addr), 64'(16));
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_l_we", 64'(l_we), 64'(0));
    chk("arst_l_addr", 64'(l_addr), 64'(0));
    chk("arst_llr_ready", 64'(llr_ready), 64'(0));
    chk("arst_mtx_addr", 64'(mtx_addr), 64'(0));
    chk("arst_dec_out", 64'(dec_out), 64'(0));
    llr_valid = 1'b0;
    rst = 1'b0;
    tick();
    do_start();
    llr_valid = 1'b1; llr_data = 8'hEE;
    tick();
    llr_valid = 1'b0;
    chk("reload_l_we", 64'(l_we), 64'(1));
    chk("reload_l_addr", 64'(l_addr), 64'(0));
    chk("reload_l_data", 64'(l_data), 64'(8'hEE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
